// File: rtl/axi4_stream_tg_pkg.sv
// Shared definitions for the AXI4-Stream traffic initiator/consumer pair:
// tlast trigger decoding, pacer states and the expected-tlast rule.
package axi4_stream_tg_pkg;

  typedef enum logic [1:0] {
    TRIG_PACKET = 2'd0,
    TRIG_FRAME  = 2'd1,
    TRIG_STREAM = 2'd2
  } tlast_trigger_e;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_PAUSE = 2'd1,
    ST_DONE  = 2'd2
  } pacer_state_e;

  // Map the 64-bit ASCII trigger parameter onto the enum; unknown text
  // falls back to whole-stream framing.
  function automatic tlast_trigger_e decode_trigger(input logic [63:0] trig_str);
    tlast_trigger_e trig;
    case (trig_str)
      {16'h0000, "PACKET"}:   trig = TRIG_PACKET;
      {24'h000000, "FRAME"}:  trig = TRIG_FRAME;
      {16'h0000, "STREAM"}:   trig = TRIG_STREAM;
      default:                trig = TRIG_STREAM;
    endcase
    return trig;
  endfunction

  // tlast is due on the last beat of the unit selected by the trigger.
  function automatic logic expected_tlast(input logic [31:0]    beat,
                                          input logic [31:0]    pkt,
                                          input logic [31:0]    frm,
                                          input logic [31:0]    tpp,
                                          input logic [31:0]    ppf,
                                          input logic [31:0]    fps,
                                          input tlast_trigger_e trig);
    logic last_beat;
    logic last_pkt;
    logic last_frm;
    logic result;
    last_beat = (beat == (tpp - 32'd1));
    last_pkt  = (pkt == (ppf - 32'd1));
    last_frm  = (frm == (fps - 32'd1));
    case (trig)
      TRIG_PACKET: result = last_beat;
      TRIG_FRAME:  result = last_beat & last_pkt;
      TRIG_STREAM: result = last_beat & last_pkt & last_frm;
      default:     result = last_beat & last_pkt & last_frm;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/axi4_stream_ready_pacer.sv
// tready duty-cycle generator: CyclesReady cycles high, CyclesPause cycles
// low, repeating; locks high once the stream is done. Counts clock cycles,
// independent of whether beats are actually transferred.
module axi4_stream_ready_pacer
  import axi4_stream_tg_pkg::*;
#(
  parameter int unsigned CyclesReady = 2,
  parameter int unsigned CyclesPause = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic done_i,
  output logic tready_o
);

  pacer_state_e state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         tready_q, tready_d;

  // Next state: cnt_q is the number of cycles the current state has already
  // been presented on tready; reset leaves it at 0 so the first READY
  // window is full length.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (done_i) begin
      state_d = ST_DONE;
      cnt_d   = 32'd0;
    end else begin
      case (state_q)
        ST_READY: begin
          if (cnt_q >= CyclesReady) begin
            state_d = (CyclesPause != 32'd0) ? ST_PAUSE : ST_READY;
            cnt_d   = 32'd1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_PAUSE: begin
          if (cnt_q >= CyclesPause) begin
            state_d = ST_READY;
            cnt_d   = 32'd1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_DONE: begin
          cnt_d = 32'd0;
        end
        default: begin
          state_d = ST_READY;
          cnt_d   = 32'd0;
        end
      endcase
    end
    tready_d = (state_d != ST_PAUSE);
  end

  // State, counter and registered tready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_READY;
      cnt_q    <= 32'd0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tready_q <= tready_d;
    end
  end

  assign tready_o = tready_q;

endmodule

// File: rtl/axi4_stream_consumer_type_1.sv
// AXI4-Stream sink/checker: paces tready, tracks packet/frame/stream
// position of accepted beats and flags route, data, tlast and overflow
// errors with sticky flags plus a saturating error counter.
module axi4_stream_consumer_type_1
  import axi4_stream_tg_pkg::*;
#(
  parameter int unsigned AxiStreamConsumerIfTDataWidth = 32,
  parameter int unsigned AxiStreamConsumerIfTIdWidth   = 8,
  parameter int unsigned AxiStreamConsumerIfTDestWidth = 8,
  parameter logic [AxiStreamConsumerIfTIdWidth-1:0]   AxiStreamConsumerIfTId   = 8'h11,
  parameter logic [AxiStreamConsumerIfTDestWidth-1:0] AxiStreamConsumerIfTDest = 8'hDE,
  parameter int unsigned AxiStreamConsumerIfCyclesReady         = 2,
  parameter int unsigned AxiStreamConsumerIfCyclesPause         = 4,
  parameter int unsigned AxiStreamConsumerIfTransfersPerPacket  = 2,
  parameter int unsigned AxiStreamConsumerIfPacketsPerFrame     = 2,
  parameter int unsigned AxiStreamConsumerIfFramesPerStream     = 2,
  parameter logic [63:0] AxiStreamConsumerIfTlastFlagTrigger    = {16'h0000, "STREAM"}
) (
  input  logic                                     clk_s_axis_i,
  input  logic                                     rst_s_axis_i,
  input  logic                                     s_axis_tvalid_i,
  output logic                                     s_axis_tready_o,
  input  logic [AxiStreamConsumerIfTDataWidth-1:0] s_axis_tdata_i,
  input  logic                                     s_axis_tlast_i,
  input  logic [AxiStreamConsumerIfTIdWidth-1:0]   s_axis_tid_i,
  input  logic [AxiStreamConsumerIfTDestWidth-1:0] s_axis_tdest_i,
  output logic [31:0]                              transfer_count_o,
  output logic [15:0]                              error_count_o,
  output logic                                     err_route_o,
  output logic                                     err_data_o,
  output logic                                     err_tlast_o,
  output logic                                     err_overflow_o,
  output logic                                     done_o
);

  localparam int unsigned DW = AxiStreamConsumerIfTDataWidth;
  localparam tlast_trigger_e Trigger = decode_trigger(AxiStreamConsumerIfTlastFlagTrigger);
  localparam logic [31:0] LastBeat = AxiStreamConsumerIfTransfersPerPacket - 32'd1;
  localparam logic [31:0] LastPkt  = AxiStreamConsumerIfPacketsPerFrame - 32'd1;
  localparam logic [31:0] LastFrm  = AxiStreamConsumerIfFramesPerStream - 32'd1;
  localparam logic [DW-1:0] DataOne = {{(DW-1){1'b0}}, 1'b1};

  logic [31:0]   beat_q, beat_d, pkt_q, pkt_d, frm_q, frm_d;
  logic [DW-1:0] exp_data_q, exp_data_d;
  logic [DW-1:0] alt_data_q, alt_data_d;
  logic          alt_valid_q, alt_valid_d;
  logic [31:0]   transfer_count_q, transfer_count_d;
  logic [15:0]   error_count_q, error_count_d;
  logic          err_route_q, err_route_d;
  logic          err_data_q, err_data_d;
  logic          err_tlast_q, err_tlast_d;
  logic          err_overflow_q, err_overflow_d;
  logic          done_q, done_d;

  logic tready_s;
  logic accept_s;
  logic final_s;
  logic last_accept_s;
  logic exp_tlast_s;
  logic route_err_s;
  logic data_match_s;
  logic data_err_s;
  logic tlast_err_s;
  logic beat_err_s;

  axi4_stream_ready_pacer #(
    .CyclesReady (AxiStreamConsumerIfCyclesReady),
    .CyclesPause (AxiStreamConsumerIfCyclesPause)
  ) u_pacer (
    .clk_i    (clk_s_axis_i),
    .rst_i    (rst_s_axis_i),
    .done_i   (last_accept_s),
    .tready_o (tready_s)
  );

  // Per-beat checks and next values of position, data tracker and status.
  // The data tracker accepts either the in-sequence value or, right after a
  // mismatch, the resynced value received+1: a single corrupted beat and a
  // single jump in the sequence each cost exactly one error.
  always_comb begin
    accept_s      = s_axis_tvalid_i & tready_s;
    final_s       = (beat_q == LastBeat) & (pkt_q == LastPkt) & (frm_q == LastFrm);
    last_accept_s = accept_s & ~done_q & final_s;
    exp_tlast_s   = expected_tlast(beat_q, pkt_q, frm_q,
                                   AxiStreamConsumerIfTransfersPerPacket,
                                   AxiStreamConsumerIfPacketsPerFrame,
                                   AxiStreamConsumerIfFramesPerStream, Trigger);
    route_err_s   = (s_axis_tid_i != AxiStreamConsumerIfTId) |
                    (s_axis_tdest_i != AxiStreamConsumerIfTDest);
    data_match_s  = (s_axis_tdata_i == exp_data_q) |
                    (alt_valid_q & (s_axis_tdata_i == alt_data_q));
    data_err_s    = ~done_q & ~data_match_s;
    tlast_err_s   = ~done_q & (s_axis_tlast_i != exp_tlast_s);
    beat_err_s    = route_err_s | data_err_s | tlast_err_s | done_q;

    beat_d           = beat_q;
    pkt_d            = pkt_q;
    frm_d            = frm_q;
    exp_data_d       = exp_data_q;
    alt_data_d       = alt_data_q;
    alt_valid_d      = alt_valid_q;
    transfer_count_d = transfer_count_q;
    error_count_d    = error_count_q;
    err_route_d      = err_route_q;
    err_data_d       = err_data_q;
    err_tlast_d      = err_tlast_q;
    err_overflow_d   = err_overflow_q;
    done_d           = done_q | last_accept_s;

    if (accept_s) begin
      transfer_count_d = transfer_count_q + 32'd1;
      error_count_d    = (beat_err_s && (error_count_q != 16'hFFFF)) ?
                         (error_count_q + 16'd1) : error_count_q;
      err_route_d      = err_route_q | route_err_s;
      err_data_d       = err_data_q | data_err_s;
      err_tlast_d      = err_tlast_q | tlast_err_s;
      err_overflow_d   = err_overflow_q | done_q;
    end else begin
      transfer_count_d = transfer_count_q;
    end

    if (accept_s && !done_q) begin
      if (beat_q == LastBeat) begin
        beat_d = 32'd0;
        if (pkt_q == LastPkt) begin
          pkt_d = 32'd0;
          frm_d = (frm_q == LastFrm) ? 32'd0 : (frm_q + 32'd1);
        end else begin
          pkt_d = pkt_q + 32'd1;
        end
      end else begin
        beat_d = beat_q + 32'd1;
      end
      if (data_match_s) begin
        exp_data_d  = s_axis_tdata_i + DataOne;
        alt_valid_d = 1'b0;
      end else begin
        exp_data_d  = exp_data_q + DataOne;
        alt_data_d  = s_axis_tdata_i + DataOne;
        alt_valid_d = 1'b1;
      end
    end else begin
      alt_valid_d = alt_valid_q;
    end
  end

  // Status, position and data-tracker registers; reset drops all progress.
  always_ff @(posedge clk_s_axis_i) begin
    if (rst_s_axis_i) begin
      beat_q           <= 32'd0;
      pkt_q            <= 32'd0;
      frm_q            <= 32'd0;
      exp_data_q       <= {DW{1'b0}};
      alt_data_q       <= {DW{1'b0}};
      alt_valid_q      <= 1'b0;
      transfer_count_q <= 32'd0;
      error_count_q    <= 16'd0;
      err_route_q      <= 1'b0;
      err_data_q       <= 1'b0;
      err_tlast_q      <= 1'b0;
      err_overflow_q   <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      beat_q           <= beat_d;
      pkt_q            <= pkt_d;
      frm_q            <= frm_d;
      exp_data_q       <= exp_data_d;
      alt_data_q       <= alt_data_d;
      alt_valid_q      <= alt_valid_d;
      transfer_count_q <= transfer_count_d;
      error_count_q    <= error_count_d;
      err_route_q      <= err_route_d;
      err_data_q       <= err_data_d;
      err_tlast_q      <= err_tlast_d;
      err_overflow_q   <= err_overflow_d;
      done_q           <= done_d;
    end
  end

  assign s_axis_tready_o  = tready_s;
  assign transfer_count_o = transfer_count_q;
  assign error_count_o    = error_count_q;
  assign err_route_o      = err_route_q;
  assign err_data_o       = err_data_q;
  assign err_tlast_o      = err_tlast_q;
  assign err_overflow_o   = err_overflow_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_axi4_stream_consumer_type_1.sv
// Directed bench for axi4_stream_consumer_type_1. Two instances share the
// stimulus bus: u_a uses the default STREAM trigger, u_b uses PACKET and
// gets its own tlast line. Default geometry is 2x2x2 = 8 beats per stream.
module tb_axi4_stream_consumer_type_1;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast_a, tlast_b;
  logic [7:0]  tid, tdest;

  logic        tready_a, tready_b;
  logic [31:0] tc_a, tc_b;
  logic [15:0] ec_a, ec_b;
  logic        er_a, ed_a, et_a, eo_a, done_a;
  logic        er_b, ed_b, et_b, eo_b, done_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi4_stream_consumer_type_1 u_a (
    .clk_s_axis_i(clk), .rst_s_axis_i(rst),
    .s_axis_tvalid_i(tvalid), .s_axis_tready_o(tready_a),
    .s_axis_tdata_i(tdata), .s_axis_tlast_i(tlast_a),
    .s_axis_tid_i(tid), .s_axis_tdest_i(tdest),
    .transfer_count_o(tc_a), .error_count_o(ec_a),
    .err_route_o(er_a), .err_data_o(ed_a), .err_tlast_o(et_a),
    .err_overflow_o(eo_a), .done_o(done_a)
  );

  axi4_stream_consumer_type_1 #(
    .AxiStreamConsumerIfTlastFlagTrigger({16'h0000, "PACKET"})
  ) u_b (
    .clk_s_axis_i(clk), .rst_s_axis_i(rst),
    .s_axis_tvalid_i(tvalid), .s_axis_tready_o(tready_b),
    .s_axis_tdata_i(tdata), .s_axis_tlast_i(tlast_b),
    .s_axis_tid_i(tid), .s_axis_tdest_i(tdest),
    .transfer_count_o(tc_b), .error_count_o(ec_b),
    .err_route_o(er_b), .err_data_o(ed_b), .err_tlast_o(et_b),
    .err_overflow_o(eo_b), .done_o(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [31:0] d, input logic tla, input logic tlb,
                      input logic [7:0] id);
    int waited;
    waited  = 0;
    tvalid  = 1'b1;
    tdata   = d;
    tlast_a = tla;
    tlast_b = tlb;
    tid     = id;
    while (tready_a !== 1'b1 && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    check("handshake_timeout", {31'd0, (waited >= 16)}, 32'd0);
    @(negedge clk);
    tvalid  = 1'b0;
    tlast_a = 1'b0;
    tlast_b = 1'b0;
    tid     = 8'h11;
  endtask

  // Beat n (1-based) of a clean stream: data n-1, STREAM tlast on beat 8,
  // PACKET tlast on even beats.
  task automatic send_std(input int n);
    send(32'(n - 1), (n == 8), (n % 2 == 0), 8'h11);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, {tready_a, tc_a, ec_a, er_a, ed_a, et_a, eo_a, done_a} != 54'd0, 32'd0);
    check({tag, "_b"}, {tready_b, tc_b, ec_b, er_b, ed_b, et_b, eo_b, done_b} != 54'd0, 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero(tag);
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] pat;
    pat     = 12'b1100_0011_0000;
    rst     = 1'b1;
    tvalid  = 1'b0;
    tdata   = 32'd0;
    tlast_a = 1'b0;
    tlast_b = 1'b0;
    tid     = 8'h11;
    tdest   = 8'hDE;

    // Reset state, then tready duty pattern 1,1,0,0,0,0 from the first edge.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("pace_%0d", i), {31'd0, tready_a}, {31'd0, pat[11-i]});
    end

    // Clean stream of 8 beats.
    for (int n = 1; n <= 7; n++) send_std(n);
    check("a_tc_7", tc_a, 32'd7);
    check("a_notdone_7", {31'd0, done_a}, 32'd0);
    send_std(8);
    check("a_tc_8", tc_a, 32'd8);
    check("a_done", {31'd0, done_a}, 32'd1);
    check("b_done", {31'd0, done_b}, 32'd1);
    check("a_ec_clean", {16'd0, ec_a}, 32'd0);
    check("b_ec_clean", {16'd0, ec_b}, 32'd0);
    check("a_flags_clean", {28'd0, er_a, ed_a, et_a, eo_a}, 32'd0);
    check("b_flags_clean", {28'd0, er_b, ed_b, et_b, eo_b}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("done_ready_%0d", i), {31'd0, tready_a}, 32'd1);
    end

    // Two beats after done: overflow.
    send(32'd8, 1'b0, 1'b0, 8'h11);
    send(32'd9, 1'b0, 1'b0, 8'h11);
    check("ovf_tc", tc_a, 32'd10);
    check("ovf_ec_a", {16'd0, ec_a}, 32'd2);
    check("ovf_ec_b", {16'd0, ec_b}, 32'd2);
    check("ovf_flag", {31'd0, eo_a}, 32'd1);
    check("ovf_other", {29'd0, er_a, ed_a, et_a}, 32'd0);

    // Bad tid plus bad data on beat 1: two error types, one count.
    pulse_reset("rst_b");
    send(32'h55, 1'b0, 1'b0, 8'h12);
    check("route_flag", {31'd0, er_a}, 32'd1);
    check("route_data_flag", {31'd0, ed_a}, 32'd1);
    check("route_tlast_flag", {31'd0, et_a}, 32'd0);
    check("route_ec", {16'd0, ec_a}, 32'd1);
    check("route_tc", tc_a, 32'd1);

    // Corrupted beat 3, later beats in sequence.
    pulse_reset("rst_c");
    send_std(1);
    send_std(2);
    send(32'hFFFF_FFFF, 1'b0, 1'b0, 8'h11);
    check("corrupt_flag", {31'd0, ed_a}, 32'd1);
    check("corrupt_ec3", {16'd0, ec_a}, 32'd1);
    send_std(4);
    check("corrupt_ec4", {16'd0, ec_a}, 32'd1);
    for (int n = 5; n <= 8; n++) send_std(n);
    check("corrupt_done", {31'd0, done_a}, 32'd1);
    check("corrupt_ec_end", {16'd0, ec_a}, 32'd1);
    check("corrupt_ec_b", {16'd0, ec_b}, 32'd1);
    check("corrupt_tlast", {31'd0, et_a}, 32'd0);

    // PACKET trigger with missing tlast on beat 4.
    pulse_reset("rst_d");
    for (int n = 1; n <= 8; n++) begin
      if (n == 4) send(32'd3, 1'b0, 1'b0, 8'h11);
      else send_std(n);
    end
    check("pkt_tlast_flag", {31'd0, et_b}, 32'd1);
    check("pkt_ec", {16'd0, ec_b}, 32'd1);
    check("pkt_done", {31'd0, done_b}, 32'd1);
    check("stream_ec", {16'd0, ec_a}, 32'd0);
    check("stream_tlast", {31'd0, et_a}, 32'd0);

    // Reset after beat 5, then a full clean stream.
    pulse_reset("rst_e");
    for (int n = 1; n <= 5; n++) send_std(n);
    check("mid_tc5", tc_a, 32'd5);
    pulse_reset("mid_reset");
    for (int n = 1; n <= 8; n++) send_std(n);
    check("restart_tc", tc_a, 32'd8);
    check("restart_done", {31'd0, done_a}, 32'd1);
    check("restart_ec_a", {16'd0, ec_a}, 32'd0);
    check("restart_ec_b", {16'd0, ec_b}, 32'd0);
    check("restart_flags", {24'd0, er_a, ed_a, et_a, eo_a, er_b, ed_b, et_b, eo_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
